// File: rtl/move_write_ctrl.sv
// Move-write controller: validates a player's move against the board storage,
// writes the stone, and sequences whole-board clears one cell per cycle.
module move_write_ctrl #(
  parameter int BOARD_DIM = 15,
  parameter int CELLS     = 225
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_x,
  input  logic [3:0] req_y,
  input  logic       req_player,
  input  logic       clear_req,
  output logic [7:0] rd_addr,
  input  logic       rd_occ,
  output logic [7:0] wr_addr,
  output logic       wr_en,
  output logic       wr_occ,
  output logic       wr_color,
  output logic       done_valid,
  output logic [1:0] done_status,
  output logic       turn,
  output logic [7:0] move_count,
  output logic       board_full
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CHECK = 3'd1;
  localparam logic [2:0] WRITE = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] CLEAR = 3'd4;

  localparam logic [7:0] DIM      = 8'(BOARD_DIM);
  localparam logic [7:0] CELL_MAX = 8'(CELLS);
  localparam logic [7:0] CLR_LAST = 8'(CELLS - 1);

  logic [2:0] state;
  logic [3:0] x_q;
  logic [3:0] y_q;
  logic       player_q;
  logic [7:0] clr_addr;
  logic [1:0] status_q;
  logic [7:0] cell_addr;
  logic       out_of_range;

  assign cell_addr    = {4'd0, y_q} * DIM + {4'd0, x_q};
  assign out_of_range = ({4'd0, x_q} >= DIM) || ({4'd0, y_q} >= DIM);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      player_q   <= 1'b0;
      clr_addr   <= '0;
      status_q   <= '0;
      turn       <= 1'b0;
      move_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clear_req) begin
            clr_addr <= '0;
            state    <= CLEAR;
          end else if (req_valid) begin
            x_q      <= req_x;
            y_q      <= req_y;
            player_q <= req_player;
            state    <= CHECK;
          end
        end
        CHECK: begin
          state <= DONE;
          // A full board is treated as occupied so move_count can never overrun.
          if (out_of_range)
            status_q <= 2'b10;
          else if (player_q != turn)
            status_q <= 2'b11;
          else if (rd_occ || (move_count == CELL_MAX))
            status_q <= 2'b01;
          else begin
            status_q <= 2'b00;
            state    <= WRITE;
          end
        end
        WRITE: begin
          turn       <= ~turn;
          move_count <= move_count + 8'd1;
          state      <= DONE;
        end
        DONE: state <= IDLE;
        CLEAR: begin
          clr_addr <= clr_addr + 8'd1;
          if (clr_addr == CLR_LAST) begin
            turn       <= 1'b0;
            move_count <= '0;
            status_q   <= 2'b00;
            state      <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready   = (state == IDLE);
  assign rd_addr     = cell_addr;
  assign wr_addr     = (state == CLEAR) ? clr_addr : cell_addr;
  assign wr_en       = (state == WRITE) || (state == CLEAR);
  assign wr_occ      = (state == WRITE);
  assign wr_color    = (state == WRITE) && player_q;
  assign done_valid  = (state == DONE);
  assign done_status = status_q;
  assign board_full  = (move_count == CELL_MAX);

endmodule

// File: tb/tb_move_write_ctrl.sv
// Bench for move_write_ctrl: a board-level model schedules expected writes,
// completions and turn/count updates by cycle; a monitor compares every cycle.
module tb_move_write_ctrl;
  localparam int DIM   = 15;
  localparam int NCELL = 225;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_x = '0;
  logic [3:0] req_y = '0;
  logic       req_player = 1'b0;
  logic       clear_req = 1'b0;
  logic [7:0] rd_addr;
  logic       rd_occ;
  logic [7:0] wr_addr;
  logic       wr_en, wr_occ, wr_color, done_valid;
  logic [1:0] done_status;
  logic       turn;
  logic [7:0] move_count;
  logic       board_full;

  move_write_ctrl #(.BOARD_DIM(DIM), .CELLS(NCELL)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_player(req_player), .clear_req(clear_req),
    .rd_addr(rd_addr), .rd_occ(rd_occ), .wr_addr(wr_addr), .wr_en(wr_en),
    .wr_occ(wr_occ), .wr_color(wr_color), .done_valid(done_valid),
    .done_status(done_status), .turn(turn), .move_count(move_count),
    .board_full(board_full)
  );

  always #5 clock = ~clock;

  // Board storage stand-in: registered write, combinational read.
  logic st_occ [0:255];
  always @(posedge clock) if (wr_en) st_occ[wr_addr] <= wr_occ;
  assign rd_occ = st_occ[rd_addr];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: logical board, schedule of expected events keyed by cycle.
  bit m_occ [NCELL];
  bit l_turn = 1'b0;
  int l_count = 0;
  bit m_turn = 1'b0;
  int m_count = 0;
  bit exp_wr[int];
  int exp_wr_addr[int];
  bit exp_wr_occ[int];
  bit exp_wr_col[int];
  bit exp_done[int];
  int exp_st[int];
  bit exp_busy[int];
  bit upd[int];
  bit upd_turn[int];
  int upd_count[int];

  int nwr = 0;
  int last_wr_addr = -1;
  int last_wr_cyc = -1;
  int last_done_cyc = -1;
  int last_status = -1;

  always @(negedge clock) begin
    if (chk_en && reset) begin
      if (upd.exists(cyc)) begin
        m_turn  = upd_turn[cyc];
        m_count = upd_count[cyc];
      end
      chk("req_ready", int'(req_ready), exp_busy.exists(cyc) ? 0 : 1);
      chk("wr_en", int'(wr_en), exp_wr.exists(cyc) ? 1 : 0);
      if (exp_wr.exists(cyc)) begin
        chk("wr_addr", int'(wr_addr), exp_wr_addr[cyc]);
        chk("wr_occ", int'(wr_occ), int'(exp_wr_occ[cyc]));
        chk("wr_color", int'(wr_color), int'(exp_wr_col[cyc]));
      end
      if (wr_en) begin
        nwr++;
        last_wr_addr = int'(wr_addr);
        last_wr_cyc  = cyc;
      end
      chk("done_valid", int'(done_valid), exp_done.exists(cyc) ? 1 : 0);
      if (exp_done.exists(cyc)) chk("done_status", int'(done_status), exp_st[cyc]);
      if (done_valid) begin
        last_done_cyc = cyc;
        last_status   = int'(done_status);
      end
      chk("turn", int'(turn), int'(m_turn));
      chk("move_count", int'(move_count), m_count);
      chk("board_full", int'(board_full), (m_count == NCELL) ? 1 : 0);
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clock);
    while (!req_ready && n < 500) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) begin
      chk("ready_timeout", 0, 1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "req_ready never returned");
    end
    #1;
  endtask

  task automatic issue(input int x, input int y, input bit p, input bit clr, output int h);
    int st;
    int idx;
    wait_ready();
    req_x = 4'(x); req_y = 4'(y); req_player = p;
    req_valid = 1'b1; clear_req = clr;
    @(posedge clock);
    #1;
    req_valid = 1'b0; clear_req = 1'b0;
    h = cyc;
    if (clr) begin
      for (int i = 0; i < NCELL; i++) begin
        exp_wr[h+i] = 1'b1; exp_wr_addr[h+i] = i;
        exp_wr_occ[h+i] = 1'b0; exp_wr_col[h+i] = 1'b0;
        exp_busy[h+i] = 1'b1;
        m_occ[i] = 1'b0;
      end
      exp_busy[h+NCELL] = 1'b1; exp_done[h+NCELL] = 1'b1; exp_st[h+NCELL] = 0;
      upd[h+NCELL] = 1'b1; upd_turn[h+NCELL] = 1'b0; upd_count[h+NCELL] = 0;
      l_turn = 1'b0; l_count = 0;
    end else begin
      idx = y * DIM + x;
      if (x >= DIM || y >= DIM) st = 2;
      else if (p != l_turn) st = 3;
      else if (m_occ[idx] || l_count == NCELL) st = 1;
      else st = 0;
      if (st == 0) begin
        exp_wr[h+1] = 1'b1; exp_wr_addr[h+1] = idx;
        exp_wr_occ[h+1] = 1'b1; exp_wr_col[h+1] = p;
        for (int i = 0; i < 3; i++) exp_busy[h+i] = 1'b1;
        exp_done[h+2] = 1'b1; exp_st[h+2] = 0;
        m_occ[idx] = 1'b1; l_turn = ~l_turn; l_count++;
        upd[h+2] = 1'b1; upd_turn[h+2] = l_turn; upd_count[h+2] = l_count;
      end else begin
        exp_busy[h] = 1'b1; exp_busy[h+1] = 1'b1;
        exp_done[h+1] = 1'b1; exp_st[h+1] = st;
      end
    end
  endtask

  int h;
  int w0;

  initial begin
    for (int i = 0; i < 256; i++) st_occ[i] = 1'b0;
    #3;
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_done", int'(done_valid), 0);
    chk("rst_turn", int'(turn), 0);
    chk("rst_count", int'(move_count), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_status", int'(done_status), 0);
    #9 reset = 1'b1;
    @(posedge clock); #1;
    chk("ready_after_rst", int'(req_ready), 1);
    @(negedge clock); chk_en = 1'b1;

    // Black (7,7): write at 112, done two cycles after CHECK.
    issue(7, 7, 1'b0, 1'b0, h);
    wait_ready();
    chk("m1_addr", last_wr_addr, 112);
    chk("m1_wr_lat", last_wr_cyc - h, 1);
    chk("m1_done_lat", last_done_cyc - h, 2);
    chk("m1_status", last_status, 0);
    chk("m1_turn", int'(turn), 1);
    chk("m1_count", int'(move_count), 1);

    // White (7,7) occupied.
    w0 = nwr;
    issue(7, 7, 1'b1, 1'b0, h);
    wait_ready();
    chk("m2_status", last_status, 1);
    chk("m2_done_lat", last_done_cyc - h, 1);
    chk("m2_no_write", nwr, w0);
    chk("m2_turn", int'(turn), 1);

    issue(3, 3, 1'b0, 1'b0, h);
    wait_ready();
    chk("m3_status", last_status, 3);
    issue(15, 0, 1'b1, 1'b0, h);
    wait_ready();
    chk("m4_status", last_status, 2);
    chk("m4_no_write", nwr, w0);

    // Clear and move together: clear wins.
    w0 = nwr;
    issue(1, 1, 1'b1, 1'b1, h);
    wait_ready();
    chk("clr_writes", nwr - w0, NCELL);
    chk("clr_last_addr", last_wr_addr, 224);
    chk("clr_done_lat", last_done_cyc - h, NCELL);
    chk("clr_status", last_status, 0);
    chk("clr_turn", int'(turn), 0);
    chk("clr_count", int'(move_count), 0);

    // Reset in the middle of a clear.
    issue(0, 0, 1'b0, 1'b1, h);
    while (cyc < h + 100) @(negedge clock);
    #1;
    chk("clr100_addr", int'(wr_addr), 100);
    chk("clr100_wr_en", int'(wr_en), 1);
    chk_en = 1'b0;
    reset = 1'b0;
    #1;
    chk("mid_rst_wr_en", int'(wr_en), 0);
    chk("mid_rst_ready", int'(req_ready), 1);
    chk("mid_rst_done", int'(done_valid), 0);
    chk("mid_rst_wr_addr", int'(wr_addr), 0);
    exp_wr.delete(); exp_wr_addr.delete(); exp_wr_occ.delete(); exp_wr_col.delete();
    exp_done.delete(); exp_st.delete(); exp_busy.delete();
    upd.delete(); upd_turn.delete(); upd_count.delete();
    l_turn = 1'b0; l_count = 0; m_turn = 1'b0; m_count = 0;
    for (int i = 0; i < NCELL; i++) m_occ[i] = 1'b0;
    @(negedge clock); #2 reset = 1'b1;
    @(posedge clock); #1;
    chk("post_rst_ready", int'(req_ready), 1);
    chk("post_rst_count", int'(move_count), 0);
    @(negedge clock); chk_en = 1'b1;

    // Fill the board with alternating legal moves.
    for (int i = 0; i < NCELL; i++) issue(i % DIM, i / DIM, 1'(i % 2), 1'b0, h);
    wait_ready();
    chk("full_flag", int'(board_full), 1);
    chk("full_count", int'(move_count), 225);
    chk("full_turn", int'(turn), 1);
    w0 = nwr;
    issue(0, 0, 1'b1, 1'b0, h);
    wait_ready();
    chk("full_status", last_status, 1);
    chk("full_no_write", nwr, w0);
    chk("full_count_hold", int'(move_count), 225);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    chk("global_timeout", 0, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "simulation time limit reached");
  end
endmodule

// File: doc/move_write_ctrl.md
MOVE_WRITE_CTRL -- requirements
Module: move_write_ctrl

Interface
REQ-001 The block SHALL have parameter BOARD_DIM, default 15, giving the board side length in cells (coordinates 0..BOARD_DIM-1).
REQ-002 The block SHALL have parameter CELLS, default 225 (BOARD_DIM*BOARD_DIM), giving the number of board cells.
REQ-003 clock  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  move request present.
REQ-006 req_ready  output  1  block can accept a move or clear request this cycle.
REQ-007 req_x  input  4  column of requested move.
REQ-008 req_y  input  4  row of requested move.
REQ-009 req_player  input  1  requesting player: 0 = black, 1 = white.
REQ-010 clear_req  input  1  request to empty the whole board.
REQ-011 rd_addr  output  8  cell address presented to board storage read mux.
REQ-012 rd_occ  input  1  occupied bit of the cell at rd_addr, combinational from storage.
REQ-013 wr_addr  output  8  cell address for board storage write.
REQ-014 wr_en  output  1  write strobe for the cell at wr_addr, one cycle per write.
REQ-015 wr_occ  output  1  occupied bit to write.
REQ-016 wr_color  output  1  colour bit to write (0 black, 1 white).
REQ-017 done_valid  output  1  one-cycle pulse reporting request completion.
REQ-018 done_status  output  2  00 placed/cleared, 01 cell occupied, 10 out of range, 11 wrong turn.
REQ-019 turn  output  1  player whose move is expected next.
REQ-020 move_count  output  8  number of stones placed since last reset or clear.
REQ-021 board_full  output  1  high when move_count == CELLS.

Function
REQ-022 The FSM SHALL have states IDLE, CHECK, WRITE, DONE and CLEAR.
REQ-023 req_ready SHALL be high only in IDLE.
REQ-024 In IDLE, clear_req high SHALL move to CLEAR and take priority over a simultaneous req_valid.
REQ-025 In IDLE, req_valid high with clear_req low SHALL latch req_x, req_y and req_player and move to CHECK.
REQ-026 Cell address SHALL be req_y*BOARD_DIM + req_x, computed in 8 bits; in CHECK, rd_addr SHALL carry this address.
REQ-027 CHECK SHALL evaluate in order: req_x or req_y >= BOARD_DIM -> status 10; latched player != turn -> status 11; rd_occ = 1 -> status 01; otherwise proceed to WRITE.
REQ-028 A rejected request SHALL go from CHECK to DONE without asserting wr_en and without changing turn or move_count.
REQ-029 WRITE SHALL assert wr_en for exactly one cycle with wr_addr = cell address, wr_occ = 1 and wr_color = latched player; at the same edge turn SHALL toggle and move_count SHALL increment; then go to DONE.
REQ-030 DONE SHALL assert done_valid for one cycle with the recorded status, then return to IDLE.
REQ-031 Accepted-move latency SHALL be: handshake edge N, wr_en high in cycle N+2, done_valid high in cycle N+3; rejected move has done_valid high in cycle N+2.
REQ-032 CLEAR SHALL write wr_occ = 0, wr_color = 0 with wr_en high to addresses 0..CELLS-1, one per cycle in ascending order (CELLS cycles).
REQ-033 After the last CLEAR write, turn SHALL be 0, move_count SHALL be 0, and the FSM SHALL go to DONE with status 00.
REQ-034 req_valid and clear_req SHALL be ignored outside IDLE; requesters hold them until the handshake.
REQ-035 move_count SHALL never exceed CELLS; when board_full is high, every in-range request SHALL be rejected with status 01 or 11.
REQ-036 wr_en SHALL be low in IDLE, CHECK and DONE.

Reset
REQ-037 While reset is low, the FSM SHALL be IDLE, wr_en, done_valid and turn SHALL be 0, move_count SHALL be 0, and all address and status outputs SHALL be 0, asynchronously.
REQ-038 Reset asserted mid-CLEAR or mid-WRITE SHALL drop wr_en immediately; board storage contents are governed by the storage's own reset, not by this block.
REQ-039 After reset deasserts, req_ready SHALL be high from the first clock edge.

Verification
REQ-040 Reset, then black move (7,7) -> wr_en one cycle at addr 112, occ 1, colour 0; done_status 00 at N+3; turn 1; move_count 1.
REQ-041 Next request is white at (7,7) with rd_occ = 1 -> done_status 01 at N+2, no wr_en, turn stays 1.
REQ-042 Black requests (3,3) while turn = 1 -> status 11; white requests (15,0) -> status 10.
REQ-043 clear_req and req_valid asserted together in IDLE -> CLEAR taken, 225 consecutive wr_en with addrs 0..224, occ 0; then done_status 00, turn 0, move_count 0.
REQ-044 Reset pulsed at CLEAR address 100 -> wr_en low immediately, FSM IDLE, req_ready high after release.
REQ-045 225 alternating legal moves -> board_full high, move_count 225; 226th request is rejected with no write.
